// File: rtl/clint_timer_access.sv
// Sequences 64-bit mtime/mtimecmp accesses over the CLINT 32-bit register port:
// hi-lo-hi tear-free reads with bounded retry, and three-write glitch-free updates.
module clint_timer_access #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned CLINT_MEM_SIZE = 'h10000,
    parameter int unsigned ADDR_WIDTH     = $clog2(CLINT_MEM_SIZE),
    parameter int unsigned OFS_MTIME      = 'h4000,
    parameter int unsigned OFS_MTIMECMP   = 'h0,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic                  i_req_sel,
    input  logic [63:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [63:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_we,
    output logic [XLEN-1:0]       o_wdata,
    input  logic [XLEN-1:0]       i_rdata
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [ADDR_WIDTH-1:0] A_MTIME    = ADDR_WIDTH'(OFS_MTIME);
    localparam logic [ADDR_WIDTH-1:0] A_MTIMECMP = ADDR_WIDTH'(OFS_MTIMECMP);

    typedef enum logic [2:0] {
        IDLE, RD_HI0, RD_LO, RD_HI1, WR_A, WR_B, WR_C, RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    sel_q;
    logic [63:0]             wdata_q;
    logic [XLEN-1:0]         hi0_q, lo_q;
    logic [RW-1:0]           retry_q;
    logic                    ready_q, rsp_valid_q, rsp_err_q;
    logic [63:0]             rsp_rdata_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    bus_we_q, bus_we_d;
    logic [XLEN-1:0]         bus_wdata_q, bus_wdata_d;

    logic                    accept, sel_eff, hi_match, retry_left;
    logic [ADDR_WIDTH-1:0]   base;

    assign accept     = i_req_valid && ready_q;
    // At acceptance the captured select is not yet registered, so look through to the request.
    assign sel_eff    = (state_q == IDLE) ? i_req_sel : sel_q;
    assign base       = sel_eff ? A_MTIMECMP : A_MTIME;
    assign hi_match   = (i_rdata == hi0_q);
    assign retry_left = (retry_q < RW'(MAX_RETRY));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = i_req_we ? WR_A : RD_HI0;
            RD_HI0:  state_d = RD_LO;
            RD_LO:   state_d = RD_HI1;
            RD_HI1:  state_d = (hi_match || !retry_left) ? RESP : RD_LO;
            WR_A:    state_d = WR_B;
            WR_B:    state_d = WR_C;
            WR_C:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered images of the state being entered.
    always_comb begin
        addr_d      = '0;
        bus_we_d    = 1'b0;
        bus_wdata_d = '0;
        unique case (state_d)
            RD_HI0, RD_HI1: addr_d = base + ADDR_WIDTH'(4);
            RD_LO:          addr_d = base;
            WR_A: begin
                // All-ones blocks a spurious MTIP; zero blocks a carry into mtime high.
                addr_d      = base;
                bus_we_d    = 1'b1;
                bus_wdata_d = sel_eff ? '1 : '0;
            end
            WR_B: begin
                addr_d      = base + ADDR_WIDTH'(4);
                bus_we_d    = 1'b1;
                bus_wdata_d = wdata_q[63:32];
            end
            WR_C: begin
                addr_d      = base;
                bus_we_d    = 1'b1;
                bus_wdata_d = wdata_q[31:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            wdata_q     <= '0;
            hi0_q       <= '0;
            lo_q        <= '0;
            retry_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            addr_q      <= addr_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
            unique case (state_q)
                IDLE: if (accept) begin
                    sel_q   <= i_req_sel;
                    wdata_q <= i_req_wdata;
                    retry_q <= '0;
                end
                RD_HI0: hi0_q <= i_rdata;
                RD_LO:  lo_q  <= i_rdata;
                RD_HI1: begin
                    if (hi_match) begin
                        rsp_rdata_q <= {hi0_q, lo_q};
                        rsp_err_q   <= 1'b0;
                    end else if (retry_left) begin
                        hi0_q   <= i_rdata;
                        retry_q <= retry_q + RW'(1);
                    end else begin
                        rsp_rdata_q <= {i_rdata, lo_q};
                        rsp_err_q   <= 1'b1;
                    end
                end
                WR_C:    rsp_err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_addr      = addr_q;
    assign o_we        = bus_we_q;
    assign o_wdata     = bus_wdata_q;

endmodule

// File: tb/tb_clint_timer_access.sv
// Randomized bench for clint_timer_access: a small CLINT register model on the bus side
// and a 64-bit scoreboard of what each timer register should hold.
module tb_clint_timer_access;

    localparam int AW        = 16;
    localparam int MAX_RETRY = 3;
    localparam logic [AW-1:0] MT    = 16'h4000;
    localparam logic [AW-1:0] MT_HI = 16'h4004;
    localparam logic [AW-1:0] MC    = 16'h0000;
    localparam logic [AW-1:0] MC_HI = 16'h0004;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_req_valid, i_req_we, i_req_sel;
    logic [63:0]   i_req_wdata;
    logic          o_req_ready, o_rsp_valid, o_rsp_err;
    logic [63:0]   o_rsp_rdata;
    logic [AW-1:0] o_addr;
    logic          o_we;
    logic [31:0]   o_wdata, i_rdata;

    always #5 i_clk = ~i_clk;

    clint_timer_access #(
        .XLEN(32), .CLINT_MEM_SIZE('h10000), .ADDR_WIDTH(AW),
        .OFS_MTIME('h4000), .OFS_MTIMECMP('h0), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_sel(i_req_sel), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_addr(o_addr), .o_we(o_we), .o_wdata(o_wdata), .i_rdata(i_rdata)
    );

    // CLINT model: static mtime, optional hi-word disturbance for retry scenarios.
    logic [63:0] mtime    = 64'h0;
    logic [63:0] mtimecmp = '1;
    logic [47:0] wq[$];
    int          hi_cnt   = 0;
    int          hi_base  = 0;
    int          mode     = 0;
    logic        mtip;

    always @(posedge i_clk) begin
        if (o_we) begin
            wq.push_back({o_addr, o_wdata});
            case (o_addr)
                MT:      mtime[31:0]     <= o_wdata;
                MT_HI:   mtime[63:32]    <= o_wdata;
                MC:      mtimecmp[31:0]  <= o_wdata;
                MC_HI:   mtimecmp[63:32] <= o_wdata;
                default: ;
            endcase
        end else if (o_addr == MT_HI) begin
            hi_cnt <= hi_cnt + 1;
        end
    end

    always_comb begin
        i_rdata = 32'h0;
        case (o_addr)
            MT:    i_rdata = mtime[31:0];
            MT_HI: begin
                if (mode == 1)      i_rdata = (hi_cnt == hi_base) ? 32'd7 : 32'd8;
                else if (mode == 2) i_rdata = 32'(100 + hi_cnt - hi_base);
                else                i_rdata = mtime[63:32];
            end
            MC:    i_rdata = mtimecmp[31:0];
            MC_HI: i_rdata = mtimecmp[63:32];
            default: ;
        endcase
    end
    assign mtip = (mtime >= mtimecmp);

    int          n_chk = 0, n_pass = 0;
    logic [63:0] ref_t[2];
    logic [63:0] rd_last = 64'h0;
    bit          mon_mtip = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"},  64'(o_req_ready), 64'd1);
        chk({tag, "_rvalid"}, 64'(o_rsp_valid), 64'd0);
        chk({tag, "_rdata"},  o_rsp_rdata, 64'd0);
        chk({tag, "_err"},    64'(o_rsp_err), 64'd0);
        chk({tag, "_addr"},   64'(o_addr), 64'd0);
        chk({tag, "_we"},     64'(o_we), 64'd0);
        chk({tag, "_wdata"},  64'(o_wdata), 64'd0);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!o_req_ready && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        chk("ready_before", 64'(o_req_ready), 64'd1);
    endtask

    task automatic do_txn(input bit we, input bit sel, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input bit exp_err,
                          input int exp_lat, input bit noise);
        int          lat, nb, nw;
        logic [AW-1:0] b;
        logic [31:0] wa;
        wait_ready();
        nb          = wq.size();
        hi_base     = hi_cnt;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_sel   = sel;
        i_req_wdata = wd;
        @(posedge i_clk);
        lat = 0;
        do begin
            @(negedge i_clk);
            lat++;
            i_req_valid = noise && (lat < 3);
            if (noise) begin
                i_req_we    = 1'($urandom);
                i_req_sel   = 1'($urandom);
                i_req_wdata = {$urandom, $urandom};
            end
            if (lat == 2) chk("busy_not_ready", 64'(o_req_ready), 64'd0);
            if (mon_mtip) chk("mtip_low", 64'(mtip), 64'd0);
        end while (!o_rsp_valid && lat < 30);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_err", 64'(o_rsp_err), 64'(exp_err));
        chk("rsp_rdata", o_rsp_rdata, exp_rd);
        nw = wq.size() - nb;
        if (we) begin
            b  = sel ? MC : MT;
            wa = sel ? 32'hFFFF_FFFF : 32'h0;
            chk("nwrites", 64'(nw), 64'd3);
            if (nw == 3) begin
                chk("wr_a", 64'(wq[nb]),   64'({b, wa}));
                chk("wr_b", 64'(wq[nb+1]), 64'({AW'(b + 16'd4), wd[63:32]}));
                chk("wr_c", 64'(wq[nb+2]), 64'({b, wd[31:0]}));
            end
        end else begin
            chk("nwrites", 64'(nw), 64'd0);
        end
        @(negedge i_clk);
        chk("rsp_pulse", 64'(o_rsp_valid), 64'd0);
        chk("ready_after", 64'(o_req_ready), 64'd1);
    endtask

    task automatic wr(input bit sel, input logic [63:0] wd, input bit noise);
        do_txn(1'b1, sel, wd, rd_last, 1'b0, 4, noise);
        ref_t[sel] = wd;
    endtask

    task automatic rd(input bit sel, input bit noise);
        do_txn(1'b0, sel, 64'h0, ref_t[sel], 1'b0, 4, noise);
        rd_last = ref_t[sel];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp;
        int          nb;
        ref_t[0]    = 64'h0;
        ref_t[1]    = '1;
        i_rst_n     = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_sel   = 1'b0;
        i_req_wdata = 64'h0;
        #2 i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        chk_reset_outs("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        rd(1'b1, 1'b0);
        wr(1'b0, 64'd5, 1'b0);
        mon_mtip = 1'b1;
        wr(1'b1, 64'h0000_0001_0000_0010, 1'b0);
        mon_mtip = 1'b0;
        wr(1'b0, 64'h0000_0002_FFFF_FFF0, 1'b0);
        rd(1'b0, 1'b0);

        // Low word carries between the two high reads: one retry.
        mode = 1;
        exp  = {32'd8, ref_t[0][31:0]};
        do_txn(1'b0, 1'b0, 64'h0, exp, 1'b0, 6, 1'b0);
        rd_last = exp;

        // High word moves on every read: retry budget runs out.
        mode = 2;
        exp  = {32'(100 + MAX_RETRY + 1), ref_t[0][31:0]};
        do_txn(1'b0, 1'b0, 64'h0, exp, 1'b1, 4 + 2 * MAX_RETRY, 1'b0);
        rd_last = exp;
        mode = 0;

        // Reset while the high word of mtimecmp is on the bus.
        wait_ready();
        nb          = wq.size();
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_sel   = 1'b1;
        i_req_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("in_wr_b", 64'({o_we, o_addr}), 64'({1'b1, MC_HI}));
        i_rst_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("abort_writes", 64'(wq.size() - nb), 64'd1);
        ref_t[1][31:0] = 32'hFFFF_FFFF;
        rd_last        = 64'h0;
        rd(1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit sel, noise;
            sel   = 1'($urandom);
            noise = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) wr(sel, {$urandom, $urandom}, noise);
            else                           rd(sel, noise);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
